// File: rtl/mak8_pipe_pkg.sv
// Shared pipeline definitions for the MAK8 hazard unit: scoreboard entry,
// forward-select codes, event counter width and its saturating increment.
package mak8_pipe_pkg;

   // Register indices are stored zero-extended so one entry type serves any NREGS up to 256
   localparam int unsigned RA_MAX_W = 8;
   localparam int unsigned PERF_W = 16;
   localparam int unsigned FWD_SEL_RF = 0;

   typedef struct packed {
      logic                valid;
      logic [RA_MAX_W-1:0] rd;
      logic                reg_write;
      logic                is_load;
   } sb_entry_t;

   localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, rd: '0, reg_write: 1'b0, is_load: 1'b0};

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] cnt);
      return (cnt == '1) ? cnt : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/mak8_fwd_select.sv
// Per-source operand forwarding: finds the youngest in-flight writer of one
// source register, muxes its stage result and flags a not-yet-ready load.
module mak8_fwd_select
   import mak8_pipe_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned RA_W      = 3,
   parameter int unsigned FWD_DEPTH = 2,
   parameter int unsigned LOAD_LAT  = 1,
   parameter int unsigned SEL_W     = 2
) (
   input  sb_entry_t                        sb [FWD_DEPTH],
   input  logic [RA_W-1:0]                  src,
   input  logic                             src_used,
   input  logic [FWD_DEPTH-1:0][DATA_W-1:0] stage_result,
   input  logic [DATA_W-1:0]                rf_data,
   output logic [SEL_W-1:0]                 sel,
   output logic [DATA_W-1:0]                opnd,
   output logic                             load_hazard
);

   always_comb begin
      sel         = SEL_W'(FWD_SEL_RF);
      opnd        = rf_data;
      load_hazard = 1'b0;
      if (src_used && src != '0) begin
         // Scan oldest to youngest so the youngest match is the one left standing
         for (int unsigned k = FWD_DEPTH; k >= 1; k--) begin
            if (sb[k-1].valid && sb[k-1].reg_write && sb[k-1].rd == RA_MAX_W'(src)) begin
               sel         = SEL_W'(k);
               opnd        = stage_result[k-1];
               load_hazard = sb[k-1].is_load && (k <= LOAD_LAT);
            end
         end
      end
   end

endmodule

// File: rtl/mak8_hazard_unit.sv
// MAK8 pipeline hazard unit: destination scoreboard, operand forwarding,
// load-use stall and redirect flush. Event counters built only with MAK8_HZD_PERF_EN.
module mak8_hazard_unit
   import mak8_pipe_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned NREGS     = 8,
   parameter int unsigned FWD_DEPTH = 2,
   parameter int unsigned LOAD_LAT  = 1
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  run_en,
   input  logic                                  id_valid,
   input  logic [$clog2(NREGS)-1:0]              id_rs1,
   input  logic [$clog2(NREGS)-1:0]              id_rs2,
   input  logic                                  id_use1,
   input  logic                                  id_use2,
   input  logic [$clog2(NREGS)-1:0]              id_rd,
   input  logic                                  id_reg_write,
   input  logic                                  id_mem_read,
   input  logic                                  ex_redirect,
   input  logic [FWD_DEPTH-1:0][DATA_W-1:0]      stage_result,
   input  logic [DATA_W-1:0]                     rf_data1,
   input  logic [DATA_W-1:0]                     rf_data2,
   output logic                                  stall,
   output logic                                  flush,
   output logic [$clog2(FWD_DEPTH+1)-1:0]        fwd_sel1,
   output logic [$clog2(FWD_DEPTH+1)-1:0]        fwd_sel2,
   output logic [DATA_W-1:0]                     opnd1,
   output logic [DATA_W-1:0]                     opnd2,
   input  logic                                  perf_clr,
   output logic [PERF_W-1:0]                     perf_stall,
   output logic [PERF_W-1:0]                     perf_flush,
   output logic [PERF_W-1:0]                     perf_fwd
);

   localparam int unsigned RA_W  = $clog2(NREGS);
   localparam int unsigned SEL_W = $clog2(FWD_DEPTH + 1);

   // sb[k-1] describes the instruction in stage k
   sb_entry_t sb [FWD_DEPTH];
   logic      hazard1;
   logic      hazard2;

   mak8_fwd_select #(
      .DATA_W    (DATA_W),
      .RA_W      (RA_W),
      .FWD_DEPTH (FWD_DEPTH),
      .LOAD_LAT  (LOAD_LAT),
      .SEL_W     (SEL_W)
   ) u_fwd1 (
      .sb           (sb),
      .src          (id_rs1),
      .src_used     (id_use1),
      .stage_result (stage_result),
      .rf_data      (rf_data1),
      .sel          (fwd_sel1),
      .opnd         (opnd1),
      .load_hazard  (hazard1)
   );

   mak8_fwd_select #(
      .DATA_W    (DATA_W),
      .RA_W      (RA_W),
      .FWD_DEPTH (FWD_DEPTH),
      .LOAD_LAT  (LOAD_LAT),
      .SEL_W     (SEL_W)
   ) u_fwd2 (
      .sb           (sb),
      .src          (id_rs2),
      .src_used     (id_use2),
      .stage_result (stage_result),
      .rf_data      (rf_data2),
      .sel          (fwd_sel2),
      .opnd         (opnd2),
      .load_hazard  (hazard2)
   );

   // Flush is masked during reset; a redirect always wins over a load-use stall
   always_comb begin
      flush = rst_n & run_en & ex_redirect;
      stall = run_en & id_valid & (hazard1 | hazard2) & ~flush;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < FWD_DEPTH; k++) sb[k] <= SB_BUBBLE;
      end else if (run_en) begin
         for (int unsigned k = FWD_DEPTH - 1; k >= 1; k--) sb[k] <= sb[k-1];
         if (id_valid && !stall && !flush)
            sb[0] <= '{valid: 1'b1, rd: RA_MAX_W'(id_rd),
                       reg_write: id_reg_write, is_load: id_mem_read};
         else
            sb[0] <= SB_BUBBLE;
      end
   end

`ifdef MAK8_HZD_PERF_EN
   logic [PERF_W-1:0] cnt_stall;
   logic [PERF_W-1:0] cnt_flush;
   logic [PERF_W-1:0] cnt_fwd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_stall <= '0;
         cnt_flush <= '0;
         cnt_fwd   <= '0;
      end else if (perf_clr) begin
         cnt_stall <= '0;
         cnt_flush <= '0;
         cnt_fwd   <= '0;
      end else if (run_en) begin
         if (stall) cnt_stall <= sat_inc(cnt_stall);
         if (flush) cnt_flush <= sat_inc(cnt_flush);
         if (fwd_sel1 != '0 || fwd_sel2 != '0) cnt_fwd <= sat_inc(cnt_fwd);
      end
   end

   always_comb begin
      perf_stall = cnt_stall;
      perf_flush = cnt_flush;
      perf_fwd   = cnt_fwd;
   end
`else
   logic unused_perf_clr;

   always_comb begin
      perf_stall      = '0;
      perf_flush      = '0;
      perf_fwd        = '0;
      unused_perf_clr = perf_clr;
   end
`endif

endmodule

// File: tb/tb_mak8_hazard_unit.sv
// Self-checking bench for mak8_hazard_unit: directed hazard scenarios plus a
// randomized run against an in-flight instruction list model.
module tb_mak8_hazard_unit;

   localparam int DW = 8;
   localparam int NR = 8;
   localparam int RA = 3;
   localparam int D  = 2;
   localparam int LL = 1;
   localparam int SW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic run_en = 1'b0;
   logic id_valid = 1'b0;
   logic [RA-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic id_use1 = 1'b0, id_use2 = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
   logic ex_redirect = 1'b0;
   logic [D-1:0][DW-1:0] stage_result = '0;
   logic [DW-1:0] rf_data1 = '0, rf_data2 = '0;
   logic stall, flush;
   logic [SW-1:0] fwd_sel1, fwd_sel2;
   logic [DW-1:0] opnd1, opnd2;
   logic perf_clr = 1'b0;
   logic [15:0] perf_stall, perf_flush, perf_fwd;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mak8_hazard_unit #(
      .DATA_W    (DW),
      .NREGS     (NR),
      .FWD_DEPTH (D),
      .LOAD_LAT  (LL)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .run_en       (run_en),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use1      (id_use1),
      .id_use2      (id_use2),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .ex_redirect  (ex_redirect),
      .stage_result (stage_result),
      .rf_data1     (rf_data1),
      .rf_data2     (rf_data2),
      .stall        (stall),
      .flush        (flush),
      .fwd_sel1     (fwd_sel1),
      .fwd_sel2     (fwd_sel2),
      .opnd1        (opnd1),
      .opnd2        (opnd2),
      .perf_clr     (perf_clr),
      .perf_stall   (perf_stall),
      .perf_flush   (perf_flush),
      .perf_fwd     (perf_fwd)
   );

`ifdef MAK8_HZD_PERF_EN
   // Deeper instance whose load latency keeps stall high 3 of every 4 cycles
   logic s_rst_n = 1'b0;
   logic s_perf_clr = 1'b0;
   logic [3:0][DW-1:0] s_stage_result = '0;
   logic s_stall, s_flush;
   logic [2:0] s_sel1, s_sel2;
   logic [DW-1:0] s_op1, s_op2;
   logic [15:0] s_pstall, s_pflush, s_pfwd;

   mak8_hazard_unit #(
      .DATA_W    (DW),
      .NREGS     (NR),
      .FWD_DEPTH (4),
      .LOAD_LAT  (3)
   ) dut_sat (
      .clk          (clk),
      .rst_n        (s_rst_n),
      .run_en       (1'b1),
      .id_valid     (1'b1),
      .id_rs1       (3'd3),
      .id_rs2       (3'd0),
      .id_use1      (1'b1),
      .id_use2      (1'b0),
      .id_rd        (3'd3),
      .id_reg_write (1'b1),
      .id_mem_read  (1'b1),
      .ex_redirect  (1'b0),
      .stage_result (s_stage_result),
      .rf_data1     (8'h00),
      .rf_data2     (8'h00),
      .stall        (s_stall),
      .flush        (s_flush),
      .fwd_sel1     (s_sel1),
      .fwd_sel2     (s_sel2),
      .opnd1        (s_op1),
      .opnd2        (s_op2),
      .perf_clr     (s_perf_clr),
      .perf_stall   (s_pstall),
      .perf_flush   (s_pflush),
      .perf_fwd     (s_pfwd)
   );
`endif

   // Reference model: list of in-flight instructions, index k = stage k
   bit m_v  [1:D];
   int m_rd [1:D];
   bit m_rw [1:D];
   bit m_ld [1:D];
   int m_pstall, m_pflush, m_pfwd;

   function automatic void model_fwd(input int s, input bit u, input logic [DW-1:0] rf,
                                     output int sel, output logic [DW-1:0] op, output bit haz);
      sel = 0; op = rf; haz = 0;
      if (u && s != 0)
         for (int k = 1; k <= D; k++)
            if (sel == 0 && m_v[k] && m_rw[k] && m_rd[k] == s) begin
               sel = k; op = stage_result[k-1]; haz = m_ld[k] && (k <= LL);
            end
   endfunction

   function automatic bit model_stall();
      int s1, s2; logic [DW-1:0] o1, o2; bit h1, h2;
      model_fwd(int'(id_rs1), id_use1, rf_data1, s1, o1, h1);
      model_fwd(int'(id_rs2), id_use2, rf_data2, s2, o2, h2);
      return run_en && id_valid && (h1 || h2) && !ex_redirect;
   endfunction

   function automatic bit model_anyfwd();
      int s1, s2; logic [DW-1:0] o1, o2; bit h1, h2;
      model_fwd(int'(id_rs1), id_use1, rf_data1, s1, o1, h1);
      model_fwd(int'(id_rs2), id_use2, rf_data2, s2, o2, h2);
      return (s1 != 0) || (s2 != 0);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 1; k <= D; k++) begin
            m_v[k] <= 0; m_rd[k] <= 0; m_rw[k] <= 0; m_ld[k] <= 0;
         end
         m_pstall <= 0; m_pflush <= 0; m_pfwd <= 0;
      end else begin
         if (perf_clr) begin
            m_pstall <= 0; m_pflush <= 0; m_pfwd <= 0;
         end else if (run_en) begin
            if (model_stall() && m_pstall < 65535) m_pstall <= m_pstall + 1;
            if (ex_redirect && m_pflush < 65535) m_pflush <= m_pflush + 1;
            if (model_anyfwd() && m_pfwd < 65535) m_pfwd <= m_pfwd + 1;
         end
         if (run_en) begin
            for (int k = D; k >= 2; k--) begin
               m_v[k] <= m_v[k-1]; m_rd[k] <= m_rd[k-1]; m_rw[k] <= m_rw[k-1]; m_ld[k] <= m_ld[k-1];
            end
            m_v[1]  <= id_valid && !model_stall() && !ex_redirect;
            m_rd[1] <= int'(id_rd);
            m_rw[1] <= id_reg_write;
            m_ld[1] <= id_mem_read;
         end
      end
   end

   task automatic drive_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                           input int rd, input bit rw, input bit ld);
      id_valid = v; id_rs1 = RA'(rs1); id_use1 = u1; id_rs2 = RA'(rs2); id_use2 = u2;
      id_rd = RA'(rd); id_reg_write = rw; id_mem_read = ld;
   endtask

   task automatic drain();
      run_en = 1'b1; ex_redirect = 1'b0;
      drive_id(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (D + 1) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; run_en = 1'b1; ex_redirect = 1'b1;
      rf_data1 = 8'hA5; rf_data2 = 8'h3C;
      drive_id(1, 3, 1, 3, 1, 3, 1, 1);
      repeat (2) @(negedge clk);
      #2;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
      n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b want 0", flush); end
      n_cmp++; if (fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d/%0d want 0/0", fwd_sel1, fwd_sel2); end
      n_cmp++; if (opnd1 !== 8'hA5 || opnd2 !== 8'h3C) begin n_err++; $display("FAIL reset_opnd: got %h/%h want a5/3c", opnd1, opnd2); end
      n_cmp++; if (perf_stall !== 16'h0 || perf_fwd !== 16'h0) begin n_err++; $display("FAIL reset_perf: got %h/%h want 0/0", perf_stall, perf_fwd); end
      @(negedge clk);
      ex_redirect = 1'b0;
      drive_id(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
   endtask

   task automatic test_fwd_basic();
      drain();
      drive_id(1, 0, 0, 0, 0, 1, 1, 0);               // ADD r1
      @(negedge clk);
      drive_id(1, 1, 1, 0, 0, 2, 1, 0);               // ADD r2, r1
      stage_result[0] = 8'h2A; stage_result[1] = 8'h99; rf_data1 = 8'h01;
      #2;
      n_cmp++; if (fwd_sel1 !== 2'd1) begin n_err++; $display("FAIL b2b_sel: got %0d want 1", fwd_sel1); end
      n_cmp++; if (opnd1 !== 8'h2A) begin n_err++; $display("FAIL b2b_opnd: got %h want 2a", opnd1); end
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall: got %b want 0", stall); end
      n_cmp++; if (fwd_sel2 !== 2'd0) begin n_err++; $display("FAIL b2b_sel2: got %0d want 0", fwd_sel2); end
   endtask

   task automatic test_load_use();
      drain();
      drive_id(1, 0, 0, 0, 0, 3, 1, 1);               // LDB r3
      @(negedge clk);
      drive_id(1, 3, 1, 0, 0, 4, 1, 0);               // ADD r4, r3
      stage_result[0] = 8'h77; stage_result[1] = 8'h5C;
      #2;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b want 1", stall); end
      n_cmp++; if (fwd_sel1 !== 2'd1) begin n_err++; $display("FAIL lu_sel_stall: got %0d want 1", fwd_sel1); end
      @(negedge clk);
      #2;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_release: got %b want 0", stall); end
      n_cmp++; if (fwd_sel1 !== 2'd2 || opnd1 !== 8'h5C) begin n_err++; $display("FAIL lu_fwd: got %0d/%h want 2/5c", fwd_sel1, opnd1); end
      @(negedge clk);
      #2;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_once: got %b want 0", stall); end
   endtask

   task automatic test_youngest();
      drain();
      drive_id(1, 0, 0, 0, 0, 5, 1, 0);
      @(negedge clk);
      drive_id(1, 0, 0, 0, 0, 5, 1, 0);
      @(negedge clk);
      drive_id(1, 0, 0, 5, 1, 6, 1, 0);
      stage_result[0] = 8'h11; stage_result[1] = 8'h22;
      #2;
      n_cmp++; if (fwd_sel2 !== 2'd1 || opnd2 !== 8'h11) begin n_err++; $display("FAIL youngest: got %0d/%h want 1/11", fwd_sel2, opnd2); end
   endtask

   task automatic test_flush_stall();
      drain();
      drive_id(1, 0, 0, 0, 0, 3, 1, 1);               // LDB r3
      @(negedge clk);
      drive_id(1, 3, 1, 0, 0, 4, 1, 0);               // ADD r4, r3 while redirect resolves
      ex_redirect = 1'b1;
      #2;
      n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL fl_flush: got %b want 1", flush); end
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL fl_stall: got %b want 0", stall); end
      @(negedge clk);
      ex_redirect = 1'b0;
      drive_id(1, 4, 1, 3, 1, 0, 0, 0);
      stage_result[1] = 8'h9E; rf_data1 = 8'h44;
      #2;
      n_cmp++; if (fwd_sel1 !== 2'd0 || opnd1 !== 8'h44) begin n_err++; $display("FAIL fl_entry1: got %0d/%h want 0/44", fwd_sel1, opnd1); end
      n_cmp++; if (fwd_sel2 !== 2'd2 || opnd2 !== 8'h9E) begin n_err++; $display("FAIL fl_keep: got %0d/%h want 2/9e", fwd_sel2, opnd2); end
   endtask

   task automatic test_r0();
      drain();
      drive_id(1, 0, 0, 0, 0, 0, 1, 1);               // load into r0
      @(negedge clk);
      drive_id(1, 0, 1, 0, 1, 2, 1, 0);
      rf_data1 = 8'h00; rf_data2 = 8'h00;
      #2;
      n_cmp++; if (fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0) begin n_err++; $display("FAIL r0_sel: got %0d/%0d want 0/0", fwd_sel1, fwd_sel2); end
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL r0_stall: got %b want 0", stall); end
   endtask

   task automatic test_freeze();
      drain();
      drive_id(1, 0, 0, 0, 0, 6, 1, 1);               // LDB r6
      @(negedge clk);
      run_en = 1'b0; ex_redirect = 1'b1;
      drive_id(1, 6, 1, 0, 0, 7, 1, 0);
      #2;
      n_cmp++; if (stall !== 1'b0 || flush !== 1'b0) begin n_err++; $display("FAIL frz_outs: got %b/%b want 0/0", stall, flush); end
      n_cmp++; if (fwd_sel1 !== 2'd1) begin n_err++; $display("FAIL frz_sel: got %0d want 1", fwd_sel1); end
      @(negedge clk);
      ex_redirect = 1'b0;
      @(negedge clk);
      run_en = 1'b1;
      #2;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL frz_held: got %b want 1", stall); end
      @(negedge clk);
      #2;
      n_cmp++; if (stall !== 1'b0 || fwd_sel1 !== 2'd2) begin n_err++; $display("FAIL frz_resume: got %b/%0d want 0/2", stall, fwd_sel1); end
   endtask

   task automatic test_reset_mid_stall();
      drain();
      drive_id(1, 0, 0, 0, 0, 3, 1, 1);
      @(negedge clk);
      drive_id(1, 3, 1, 0, 0, 4, 1, 0);
      rf_data1 = 8'h5A;
      #2;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rms_pre: got %b want 1", stall); end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (stall !== 1'b0 || fwd_sel1 !== 2'd0 || opnd1 !== 8'h5A) begin n_err++; $display("FAIL rms_drop: got %b/%0d/%h want 0/0/5a", stall, fwd_sel1, opnd1); end
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      n_cmp++; if (stall !== 1'b0 || fwd_sel1 !== 2'd0) begin n_err++; $display("FAIL rms_clean: got %b/%0d want 0/0", stall, fwd_sel1); end
   endtask

   task automatic test_random();
      int e_sel1, e_sel2;
      logic [DW-1:0] e_op1, e_op2;
      bit e_h1, e_h2, e_stall, e_flush;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         run_en       = ($urandom_range(0, 9) != 0);
         ex_redirect  = ($urandom_range(0, 9) == 0);
         perf_clr     = ($urandom_range(0, 99) == 0);
         drive_id($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
         stage_result = (D*DW)'($urandom);
         rf_data1 = DW'($urandom); rf_data2 = DW'($urandom);
         #2;
         model_fwd(int'(id_rs1), id_use1, rf_data1, e_sel1, e_op1, e_h1);
         model_fwd(int'(id_rs2), id_use2, rf_data2, e_sel2, e_op2, e_h2);
         e_stall = model_stall();
         e_flush = run_en && ex_redirect;
         n_cmp++; if (stall !== e_stall) begin n_err++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, stall, e_stall); end
         n_cmp++; if (flush !== e_flush) begin n_err++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, flush, e_flush); end
         n_cmp++; if (fwd_sel1 !== SW'(e_sel1) || opnd1 !== e_op1) begin n_err++; $display("FAIL rnd_src1[%0d]: got %0d/%h want %0d/%h", i, fwd_sel1, opnd1, e_sel1, e_op1); end
         n_cmp++; if (fwd_sel2 !== SW'(e_sel2) || opnd2 !== e_op2) begin n_err++; $display("FAIL rnd_src2[%0d]: got %0d/%h want %0d/%h", i, fwd_sel2, opnd2, e_sel2, e_op2); end
      end
      @(negedge clk);
      perf_clr = 1'b0; run_en = 1'b1; ex_redirect = 1'b0;
      drive_id(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #2;
`ifdef MAK8_HZD_PERF_EN
      n_cmp++; if (perf_stall !== 16'(m_pstall) || perf_flush !== 16'(m_pflush) || perf_fwd !== 16'(m_pfwd)) begin
         n_err++; $display("FAIL rnd_perf: got %0d/%0d/%0d want %0d/%0d/%0d", perf_stall, perf_flush, perf_fwd, m_pstall, m_pflush, m_pfwd); end
`else
      n_cmp++; if (perf_stall !== 16'h0 || perf_flush !== 16'h0 || perf_fwd !== 16'h0) begin
         n_err++; $display("FAIL rnd_perf_off: got %0d/%0d/%0d want 0/0/0", perf_stall, perf_flush, perf_fwd); end
`endif
   endtask

   task automatic test_perf();
`ifdef MAK8_HZD_PERF_EN
      @(negedge clk);
      s_rst_n = 1'b1;
      repeat (400) @(negedge clk);
      #2;
      n_cmp++; if (s_pstall !== 16'd300) begin n_err++; $display("FAIL sat_early_stall: got %0d want 300", s_pstall); end
      n_cmp++; if (s_pfwd !== 16'd399) begin n_err++; $display("FAIL sat_early_fwd: got %0d want 399", s_pfwd); end
      repeat (93336 - 400) @(negedge clk);
      #2;
      n_cmp++; if (s_pstall !== 16'hFFFF) begin n_err++; $display("FAIL sat_stall: got %h want ffff", s_pstall); end
      n_cmp++; if (s_pfwd !== 16'hFFFF || s_pflush !== 16'h0) begin n_err++; $display("FAIL sat_other: got %h/%h want ffff/0", s_pfwd, s_pflush); end
      @(negedge clk);
      s_perf_clr = 1'b1;
      @(negedge clk);
      s_perf_clr = 1'b0;
      #2;
      n_cmp++; if (s_pstall !== 16'h0 || s_pfwd !== 16'h0) begin n_err++; $display("FAIL sat_clr: got %h/%h want 0/0", s_pstall, s_pfwd); end
`else
      perf_clr = 1'b1;
      @(negedge clk);
      perf_clr = 1'b0;
      drive_id(1, 0, 0, 0, 0, 3, 1, 1);
      @(negedge clk);
      drive_id(1, 3, 1, 0, 0, 4, 1, 0);
      @(negedge clk);
      #2;
      n_cmp++; if (perf_stall !== 16'h0 || perf_fwd !== 16'h0) begin n_err++; $display("FAIL perf_off: got %h/%h want 0/0", perf_stall, perf_fwd); end
`endif
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fwd_basic();
      test_load_use();
      test_youngest();
      test_flush_stall();
      test_r0();
      test_freeze();
      test_reset_mid_stall();
      test_random();
      test_perf();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mak8_hazard_unit.md
MAK8_HAZARD_UNIT -- requirements
Module: mak8_hazard_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning register/forward data width.
REQ-002 SHALL have parameter NREGS, default 8, meaning architectural register count; RA_W = clog2(NREGS).
REQ-003 SHALL have parameter FWD_DEPTH, default 2, meaning tracked in-flight stages after decode (stage 1 = EX .. FWD_DEPTH = last pre-writeback); range 1..4.
REQ-004 SHALL have parameter LOAD_LAT, default 1, meaning a load result is forwardable from stage LOAD_LAT+1 onward; 0 <= LOAD_LAT < FWD_DEPTH.
REQ-005 SHALL have ports: clk in 1, clock; rst_n in 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports: run_en in 1, pipeline advance enable; id_valid in 1, decode instruction present; id_rs1, id_rs2 in RA_W, sources; id_use1, id_use2 in 1, source actually read; id_rd in RA_W, destination; id_reg_write in 1; id_mem_read in 1, instruction is load.
REQ-007 SHALL have ports: ex_redirect in 1, taken branch/jump resolved in stage 1; stage_result in FWD_DEPTH x DATA_W, result of each stage; rf_data1, rf_data2 in DATA_W, raw register-file reads.
REQ-008 SHALL have ports: stall out 1; flush out 1; fwd_sel1, fwd_sel2 out clog2(FWD_DEPTH+1), 0 = regfile, k = stage k; opnd1, opnd2 out DATA_W, forwarded operands; perf_clr in 1; perf_stall, perf_flush, perf_fwd out 16, event counters.

Function
REQ-009 SHALL keep a scoreboard shift register of FWD_DEPTH entries {valid, rd, reg_write, is_load}; entry k describes the instruction in stage k.
REQ-010 SHALL, on each clk edge with run_en=1, shift entry k into k+1, discard entry FWD_DEPTH, and load entry 1 from decode when id_valid & !stall & !flush, else load entry 1 invalid (bubble).
REQ-011 SHALL freeze the scoreboard and all counters while run_en=0; stall and flush SHALL read 0 then.
REQ-012 SHALL match source s against entry k when entry valid, reg_write=1, rd==s, id_use_s=1 and s!=0 (register 0 never forwarded or stalled).
REQ-013 SHALL select the youngest matching entry (lowest k) for forwarding; fwd_sel = k, opnd = stage_result[k]; no match gives fwd_sel=0, opnd=rf_data; combinational, zero latency.
REQ-014 SHALL assert stall combinationally when id_valid and the youngest match for either source is a load with k <= LOAD_LAT; fwd_sel then still reports k.
REQ-015 SHALL assert flush combinationally when ex_redirect=1 and run_en=1; flush overrides stall (stall forced 0) and the decode instruction SHALL not enter the scoreboard.
REQ-016 SHALL leave entries 1..FWD_DEPTH untouched by flush (redirecting instruction and older complete).
REQ-017 SHALL resolve a multi-cycle load-use stall automatically: stall deasserts the cycle the load reaches stage LOAD_LAT+1.

Reset
REQ-018 SHALL, while rst_n=0, clear all scoreboard valid bits and counters; stall=0, flush=0, fwd_sel1=fwd_sel2=0, opnd = rf_data.
REQ-019 SHALL, on reset asserted mid-stall, drop stall on the same edge with no state retained.

Configuration
REQ-020 SHALL compile counters only when MAK8_HZD_PERF_EN is defined: perf_stall/perf_flush counts cycles with stall/flush, perf_fwd counts cycles with any fwd_sel!=0; 16-bit saturating at 16'hFFFF; perf_clr synchronous clear, priority over increment.
REQ-021 SHALL, without MAK8_HZD_PERF_EN, keep the ports and drive perf_* constant 0, perf_clr ignored.

Structure
REQ-022 SHALL place the scoreboard entry struct, fwd_sel encodings and counter width constant in package mak8_pipe_pkg.
REQ-023 SHALL implement per-source matching/mux in one sub-module mak8_fwd_select, instanced twice.

Verification
REQ-024 SHALL cover: ADD r1 then ADD r2,r1 back-to-back, stage_result[1]=8'h2A -> fwd_sel1=1, opnd1=8'h2A, stall=0.
REQ-025 SHALL cover: LDB r3 then ADD r4,r3 (LOAD_LAT=1) -> stall=1 exactly one cycle, next cycle fwd_sel1=2, opnd1=stage_result[2].
REQ-026 SHALL cover: r5 written in stages 1 and 2 (results 8'h11, 8'h22), reader of r5 -> opnd=8'h11 (youngest wins).
REQ-027 SHALL cover: ex_redirect=1 coincident with a load-use stall -> flush=1, stall=0, entry 1 invalid next cycle.
REQ-028 SHALL cover: writer and reader of r0 -> fwd_sel=0, stall=0; with MAK8_HZD_PERF_EN, 70000 stall cycles -> perf_stall=16'hFFFF, perf_clr -> 0.
